// File: rtl/uart_tx_feeder.sv
// Feeds UART transmitter from a word FIFO: each buffered word is sent LSB byte first,
// one start pulse per byte, pacing on the transmitter's busy flag rising then falling.
module uart_tx_feeder #(
    parameter int WORD_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [WORD_W-1:0]        in_data,
    output logic                     in_ready,
    output logic [7:0]               tx_data,
    output logic                     tx_start,
    input  logic                     tx_busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     idle
);

    localparam int NBYTES = WORD_W / 8;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_HI,
        S_WAIT_LO
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [WORD_W-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0]    byte_idx_q, byte_idx_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_start_q, tx_start_d;

    logic                push;
    logic                pop;
    logic [WORD_W-1:0]   head_word;
    logic [WORD_W-1:0]   shifted;

    // in_ready comes only from the registered count, keeping tx_busy off the upstream path
    assign in_ready   = (count_q < FULL_CNT);
    assign push       = in_valid && in_ready;
    assign head_word  = mem_q[rd_ptr_q];
    assign shifted    = shift_q >> 8;

    assign tx_data    = tx_data_q;
    assign tx_start   = tx_start_q;
    assign fifo_count = count_q;
    assign idle       = (state_q == S_IDLE) && (count_q == '0);

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        byte_idx_d = byte_idx_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        pop        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop        = 1'b1;
                    shift_d    = head_word;
                    byte_idx_d = '0;
                    tx_data_d  = head_word[7:0];
                    tx_start_d = 1'b1;
                    state_d    = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (tx_busy) begin
                    state_d = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (!tx_busy) begin
                    if (byte_idx_q != LAST_IDX) begin
                        shift_d    = shifted;
                        byte_idx_d = byte_idx_q + IDX_W'(1);
                        tx_data_d  = shifted[7:0];
                        tx_start_d = 1'b1;
                        state_d    = S_WAIT_HI;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            shift_q    <= '0;
            byte_idx_q <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            shift_q    <= shift_d;
            byte_idx_q <= byte_idx_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
        end
    end

endmodule
